id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with load-use interlock for the five-stage MIPS pipeline. Captures decoded ID-stage operands and control each cycle and presents them as the E_* signals consumed by the EX stage and the forwarding detector. Detects load-use hazards, stalls PC and IF/ID, and inserts a bubble into EX. Also squashes on branch flush and clears register writes to $0, so downstream forwarding never matches on register 0.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall/bubble counters

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- D_Rs, D_Rt, D_Rd  in  5 each  ID-stage register specifiers
- D_BusA, D_BusB  in  32 each  register-file read data
- D_Imm32  in  32  extended immediate
- D_ALUctr  in  4  ALU operation
- D_ALUSrc, D_RegDst, D_RegWr, D_MemWr, D_MemtoReg  in  1 each  decoded control
- D_UsesRs, D_UsesRt  in  1 each  ID instruction actually reads Rs / Rt
- Flush  in  1  taken branch/jump resolved; squash the ID instruction
- E_Rs, E_Rt, E_Rw  out  5 each  EX-stage specifiers; E_Rw = RegDst ? Rd : Rt
- E_BusA, E_BusB, E_Imm32  out  32 each  EX operands
- E_ALUctr  out  4
- E_ALUSrc, E_RegWr, E_MemWr, E_MemtoReg  out  1 each
- E_Valid  out  1  EX holds a real instruction (0 = bubble)
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- StallCnt, FlushCnt  out  CNT_W each  saturating event counters

## Operation
- LoadUse = E_Valid & E_MemtoReg & E_RegWr & (E_Rw != 0) & ((D_UsesRs & D_Rs == E_Rw) | (D_UsesRt & D_Rt == E_Rw)).
- Stall = LoadUse & ~Flush. Flush has priority because the ID instruction is discarded anyway.
- The next-state register update has three modes:
  - LOAD (~Flush & ~LoadUse): capture all D_* fields. E_Rw = D_RegDst ? D_Rd : D_Rt. E_RegWr = D_RegWr & (selected Rw != 0). E_Valid = 1.
  - BUBBLE (Flush | LoadUse): every control bit = 0, E_Rs = E_Rt = E_Rw = 0, data and immediate = 0, E_ALUctr = 0, E_Valid = 0.
  - No HOLD mode. EX is never frozen; a stall always produces a bubble.
- StallCnt increments on each cycle with Stall = 1. FlushCnt increments on each cycle with Flush = 1. Both saturate at all-ones and never wrap.
- A single load-use hazard costs exactly one bubble. After the bubble, E_MemtoReg = 0, so Stall drops and the dependent instruction loads normally. Its operand is then supplied by W-stage forwarding.
- Back-to-back loads with a chain of dependencies produce one bubble per dependent load.
- E_Rw = 0 with D_RegWr = 1 is loaded with E_RegWr = 0 and E_Valid = 1.

## Timing
- Reset (rst_n low, asynchronous) forces every registered output to 0, including E_Valid, StallCnt and FlushCnt. Stall is therefore 0 while in reset.
- Release of reset is sampled synchronously. The first capture happens on the first rising edge with rst_n high.
- Latency: D_* to E_* is 1 cycle.
- Stall is a function of current E_* state and D_* inputs only. It is valid in the same cycle and has no registered delay.
- Reset asserted mid-stall: outputs clear immediately. The pending bubble is discarded, and counters clear.
- Flush and LoadUse in the same cycle: Stall = 0, bubble inserted, FlushCnt increments, StallCnt unchanged.

## Test plan
- Reset: drive D_* nonzero and pulse rst_n low between edges -> all E_* outputs, Stall, StallCnt and FlushCnt read 0 immediately, without waiting for a clock edge.
- Pass-through: R-type, D_Rs=1, D_Rt=2, D_Rd=3, D_RegDst=1, D_RegWr=1, BusA=0x11, BusB=0x22 -> next cycle E_Rw=3, E_RegWr=1, E_BusA=0x11, E_BusB=0x22, E_Valid=1, Stall=0.
- Load-use: lw to $8 loaded (E_MemtoReg=1, E_Rw=8), then ID has add with D_Rs=8 and D_UsesRs=1 -> Stall=1 that cycle. Next cycle E_Valid=0 and all controls 0, Stall=0, StallCnt=1. The following cycle the add appears with E_Valid=1.
- No false stall: lw to $0, or D_UsesRt=0 with D_Rt matching E_Rw -> Stall=0 and no bubble.
- Flush priority: load-use condition present and Flush=1 -> Stall=0, bubble next cycle, FlushCnt=1, StallCnt=0.
- $0 write and saturation: D_RegWr=1 with selected Rw=0 -> E_RegWr=0, E_Valid=1. With CNT_W=2, hold the stall condition across 5 events -> StallCnt stays at 3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID-to-EX pipeline bundle: decoded ID operands/control in, EX-stage view and stall out.
interface id_ex_stage_if;
    logic [4:0]  D_Rs;
    logic [4:0]  D_Rt;
    logic [4:0]  D_Rd;
    logic [31:0] D_BusA;
    logic [31:0] D_BusB;
    logic [31:0] D_Imm32;
    logic [3:0]  D_ALUctr;
    logic        D_ALUSrc;
    logic        D_RegDst;
    logic        D_RegWr;
    logic        D_MemWr;
    logic        D_MemtoReg;
    logic        D_UsesRs;
    logic        D_UsesRt;
    logic        Flush;

    logic [4:0]  E_Rs;
    logic [4:0]  E_Rt;
    logic [4:0]  E_Rw;
    logic [31:0] E_BusA;
    logic [31:0] E_BusB;
    logic [31:0] E_Imm32;
    logic [3:0]  E_ALUctr;
    logic        E_ALUSrc;
    logic        E_RegWr;
    logic        E_MemWr;
    logic        E_MemtoReg;
    logic        E_Valid;
    logic        Stall;

    modport master (
        output D_Rs, D_Rt, D_Rd, D_BusA, D_BusB, D_Imm32, D_ALUctr,
               D_ALUSrc, D_RegDst, D_RegWr, D_MemWr, D_MemtoReg,
               D_UsesRs, D_UsesRt, Flush,
        input  E_Rs, E_Rt, E_Rw, E_BusA, E_BusB, E_Imm32, E_ALUctr,
               E_ALUSrc, E_RegWr, E_MemWr, E_MemtoReg, E_Valid, Stall
    );

    modport slave (
        input  D_Rs, D_Rt, D_Rd, D_BusA, D_BusB, D_Imm32, D_ALUctr,
               D_ALUSrc, D_RegDst, D_RegWr, D_MemWr, D_MemtoReg,
               D_UsesRs, D_UsesRt, Flush,
        output E_Rs, E_Rt, E_Rw, E_BusA, E_BusB, E_Imm32, E_ALUctr,
               E_ALUSrc, E_RegWr, E_MemWr, E_MemtoReg, E_Valid, Stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, branch squash and $0 write suppression.
// Latency: D_* to E_* one cycle; Stall is combinational from current E_* state and D_* inputs.
// Backpressure: Stall holds PC and IF/ID; EX never freezes, a stall or flush always loads a bubble.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [31:0] imm;
        logic [3:0]  aluctr;
        logic        alusrc;
        logic        regwr;
        logic        memwr;
        logic        memtoreg;
    } ex_t;

    ex_t        ex_q;
    ex_t        ex_nxt;
    logic [4:0] sel_rw;
    logic       rs_hit;
    logic       rt_hit;
    logic       load_use;
    logic       stall;

    // E_RegWr is already cleared for $0 destinations, so no separate E_Rw != 0 term is needed
    // for correctness; it is kept explicit so the hazard reads the same as the pipeline rule.
    assign rs_hit   = bus.D_UsesRs & (bus.D_Rs == ex_q.rw);
    assign rt_hit   = bus.D_UsesRt & (bus.D_Rt == ex_q.rw);
    assign load_use = ex_q.valid & ex_q.memtoreg & ex_q.regwr & (ex_q.rw != 5'd0) & (rs_hit | rt_hit);
    assign stall    = load_use & ~bus.Flush;
    assign sel_rw   = bus.D_RegDst ? bus.D_Rd : bus.D_Rt;

    always_comb begin
        ex_nxt = '0;
        if (!(bus.Flush || load_use)) begin
            ex_nxt.valid    = 1'b1;
            ex_nxt.rs       = bus.D_Rs;
            ex_nxt.rt       = bus.D_Rt;
            ex_nxt.rw       = sel_rw;
            ex_nxt.busa     = bus.D_BusA;
            ex_nxt.busb     = bus.D_BusB;
            ex_nxt.imm      = bus.D_Imm32;
            ex_nxt.aluctr   = bus.D_ALUctr;
            ex_nxt.alusrc   = bus.D_ALUSrc;
            ex_nxt.regwr    = bus.D_RegWr & (sel_rw != 5'd0);
            ex_nxt.memwr    = bus.D_MemWr;
            ex_nxt.memtoreg = bus.D_MemtoReg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            ex_q <= ex_nxt;
            if (stall && (StallCnt != {CNT_W{1'b1}})) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (bus.Flush && (FlushCnt != {CNT_W{1'b1}})) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end

    assign bus.Stall      = stall;
    assign bus.E_Valid    = ex_q.valid;
    assign bus.E_Rs       = ex_q.rs;
    assign bus.E_Rt       = ex_q.rt;
    assign bus.E_Rw       = ex_q.rw;
    assign bus.E_BusA     = ex_q.busa;
    assign bus.E_BusB     = ex_q.busb;
    assign bus.E_Imm32    = ex_q.imm;
    assign bus.E_ALUctr   = ex_q.aluctr;
    assign bus.E_ALUSrc   = ex_q.alusrc;
    assign bus.E_RegWr    = ex_q.regwr;
    assign bus.E_MemWr    = ex_q.memwr;
    assign bus.E_MemtoReg = ex_q.memtoreg;

endmodule
